// File: rtl/demod_iq_integrator_if.sv
// Sample bus into the I/Q integrator (N_CH channels x LANES samples per clock) and its result bus.
// No backpressure: the producer presents one word per clock qualified by in_valid.
interface demod_iq_integrator_if #(
  parameter int N_CH  = 2,
  parameter int LANES = 5,
  parameter int DW    = 16,
  parameter int AW    = 32
);
  logic [N_CH*LANES*DW-1:0] in_i;
  logic [N_CH*LANES*DW-1:0] in_q;
  logic                     in_valid;
  logic [N_CH*AW-1:0]       i_val;
  logic [N_CH*AW-1:0]       q_val;
  logic                     iq_valid;

  modport master (
    output in_i, in_q, in_valid,
    input  i_val, q_val, iq_valid
  );

  modport slave (
    input  in_i, in_q, in_valid,
    output i_val, q_val, iq_valid
  );
endinterface

// File: rtl/demod_iq_integrator.sv
// Trigger-started, delayed, saturating I/Q window integrator; result strobe on the L-th valid word after D valid words.
// No backpressure: every in_valid word is consumed or discarded in the cycle it arrives.
module demod_iq_integrator #(
  parameter int N_CH  = 2,
  parameter int LANES = 5,
  parameter int DW    = 16,
  parameter int AW    = 32,
  parameter int LW    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LW-1:0]          cfg_delay,
  input  logic [LW-1:0]          cfg_length,
  input  logic                   cfg_load,
  input  logic                   trigger,
  demod_iq_integrator_if.slave   bus,
  output logic                   busy,
  output logic                   overrun
);

  localparam int SW = DW + $clog2(LANES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_INTEG = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]        cfg_delay_q, cfg_delay_d;
  logic [LW-1:0]        cfg_length_q, cfg_length_d;
  logic                 trig_d_q, trig_d_d;
  logic                 overrun_q, overrun_d;
  logic                 iq_valid_q, iq_valid_d;
  logic [N_CH*AW-1:0]   i_val_q, i_val_d;
  logic [N_CH*AW-1:0]   q_val_q, q_val_d;
  logic signed [AW-1:0] acc_i_q [N_CH];
  logic signed [AW-1:0] acc_i_d [N_CH];
  logic signed [AW-1:0] acc_q_q [N_CH];
  logic signed [AW-1:0] acc_q_d [N_CH];

  logic signed [SW-1:0] sum_i [N_CH];
  logic signed [SW-1:0] sum_q [N_CH];
  logic signed [AW-1:0] nxt_i [N_CH];
  logic signed [AW-1:0] nxt_q [N_CH];

  logic                 trig_evt;
  logic [LW-1:0]        cnt_inc;
  logic [LW-1:0]        eff_delay;
  logic [LW-1:0]        eff_length;

  // Two's-complement add clamped to the AW-bit range; a clamped value can still move back inward.
  function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b);
    logic [AW:0] s;
    s = {a[AW-1], a} + {b[AW-1], b};
    if (s[AW] != s[AW-1]) begin
      sat_add = s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      sat_add = s[AW-1:0];
    end
  endfunction

  assign trig_evt   = trigger & ~trig_d_q;
  assign cnt_inc    = cnt_q + LW'(1);
  assign eff_delay  = cfg_load ? cfg_delay  : cfg_delay_q;
  assign eff_length = cfg_load ? cfg_length : cfg_length_q;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      sum_i[c] = '0;
      sum_q[c] = '0;
      for (int l = 0; l < LANES; l++) begin
        sum_i[c] = sum_i[c] + SW'($signed(bus.in_i[(c*LANES+l)*DW +: DW]));
        sum_q[c] = sum_q[c] + SW'($signed(bus.in_q[(c*LANES+l)*DW +: DW]));
      end
      nxt_i[c] = sat_add(acc_i_q[c], AW'(sum_i[c]));
      nxt_q[c] = sat_add(acc_q_q[c], AW'(sum_q[c]));
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cfg_delay_d  = cfg_delay_q;
    cfg_length_d = cfg_length_q;
    trig_d_d     = trigger;
    overrun_d    = overrun_q;
    iq_valid_d   = 1'b0;
    i_val_d      = i_val_q;
    q_val_d      = q_val_q;
    for (int c = 0; c < N_CH; c++) begin
      acc_i_d[c] = acc_i_q[c];
      acc_q_d[c] = acc_q_q[c];
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_load) begin
          cfg_delay_d  = cfg_delay;
          cfg_length_d = cfg_length;
          overrun_d    = 1'b0;
        end
        if (trig_evt) begin
          cnt_d = '0;
          for (int c = 0; c < N_CH; c++) begin
            acc_i_d[c] = '0;
            acc_q_d[c] = '0;
          end
          if (eff_delay != '0) begin
            state_d = S_DELAY;
          end else if (eff_length != '0) begin
            state_d = S_INTEG;
          end else begin
            state_d    = S_DONE;
            i_val_d    = '0;
            q_val_d    = '0;
            iq_valid_d = 1'b1;
          end
        end
      end

      S_DELAY: begin
        if (bus.in_valid) begin
          if (cnt_inc == cfg_delay_q) begin
            cnt_d = '0;
            if (cfg_length_q != '0) begin
              state_d = S_INTEG;
            end else begin
              state_d    = S_DONE;
              i_val_d    = '0;
              q_val_d    = '0;
              iq_valid_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      S_INTEG: begin
        if (bus.in_valid) begin
          cnt_d = cnt_inc;
          for (int c = 0; c < N_CH; c++) begin
            acc_i_d[c] = nxt_i[c];
            acc_q_d[c] = nxt_q[c];
          end
          if (cnt_inc == cfg_length_q) begin
            state_d    = S_DONE;
            iq_valid_d = 1'b1;
            for (int c = 0; c < N_CH; c++) begin
              i_val_d[c*AW +: AW] = nxt_i[c];
              q_val_d[c*AW +: AW] = nxt_q[c];
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new trigger cannot restart a window in flight; it is only flagged.
    if (state_q != S_IDLE && trig_evt) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cfg_delay_q  <= '0;
      cfg_length_q <= '0;
      trig_d_q     <= 1'b0;
      overrun_q    <= 1'b0;
      iq_valid_q   <= 1'b0;
      i_val_q      <= '0;
      q_val_q      <= '0;
      for (int c = 0; c < N_CH; c++) begin
        acc_i_q[c] <= '0;
        acc_q_q[c] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cfg_delay_q  <= cfg_delay_d;
      cfg_length_q <= cfg_length_d;
      trig_d_q     <= trig_d_d;
      overrun_q    <= overrun_d;
      iq_valid_q   <= iq_valid_d;
      i_val_q      <= i_val_d;
      q_val_q      <= q_val_d;
      for (int c = 0; c < N_CH; c++) begin
        acc_i_q[c] <= acc_i_d[c];
        acc_q_q[c] <= acc_q_d[c];
      end
    end
  end

  assign bus.i_val    = i_val_q;
  assign bus.q_val    = q_val_q;
  assign bus.iq_valid = iq_valid_q;
  assign busy         = (state_q != S_IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_demod_iq_integrator.sv
// Directed bench: two integrators (AW=32 and AW=20) share stimulus; results checked against hand-computed sums.
module tb_demod_iq_integrator;

  logic        clk;
  logic        rst;
  logic [15:0] cfg_delay;
  logic [15:0] cfg_length;
  logic        cfg_load;
  logic        trigger;
  logic        busy0, busy1;
  logic        ovr0, ovr1;

  demod_iq_integrator_if #(.N_CH(2), .LANES(5), .DW(16), .AW(32)) bus0 ();
  demod_iq_integrator_if #(.N_CH(2), .LANES(5), .DW(16), .AW(20)) bus1 ();

  assign bus1.in_i     = bus0.in_i;
  assign bus1.in_q     = bus0.in_q;
  assign bus1.in_valid = bus0.in_valid;

  demod_iq_integrator #(.N_CH(2), .LANES(5), .DW(16), .AW(32), .LW(16)) u_dut0 (
    .clk(clk), .rst(rst), .cfg_delay(cfg_delay), .cfg_length(cfg_length),
    .cfg_load(cfg_load), .trigger(trigger), .bus(bus0), .busy(busy0), .overrun(ovr0)
  );

  demod_iq_integrator #(.N_CH(2), .LANES(5), .DW(16), .AW(20), .LW(16)) u_dut1 (
    .clk(clk), .rst(rst), .cfg_delay(cfg_delay), .cfg_length(cfg_length),
    .cfg_load(cfg_load), .trigger(trigger), .bus(bus1), .busy(busy1), .overrun(ovr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     vld_tab [16];
  int     i0_tab  [16];
  int     q0_tab  [16];
  int     i1_tab  [16];
  int     q1_tab  [16];
  int     trg_tab [16];
  int     ld_tab  [16];
  bit     lane_ramp;
  longint e0 [4];
  longint e1 [4];

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic fill(input int v, input int a, input int b, input int c, input int d);
    for (int n = 0; n < 16; n++) begin
      vld_tab[n] = v;
      i0_tab[n]  = a;
      q0_tab[n]  = b;
      i1_tab[n]  = c;
      q1_tab[n]  = d;
      trg_tab[n] = (n == 0) ? 1 : 0;
      ld_tab[n]  = 0;
    end
    lane_ramp = 1'b0;
  endtask

  task automatic set_exp(input longint a, input longint b, input longint c, input longint d);
    e0[0] = a; e0[1] = b; e0[2] = c; e0[3] = d;
    e1[0] = a; e1[1] = b; e1[2] = c; e1[3] = d;
  endtask

  task automatic drive(input int n);
    bus0.in_valid = (vld_tab[n] != 0);
    trigger       = (trg_tab[n] != 0);
    cfg_load      = (ld_tab[n] != 0);
    for (int l = 0; l < 5; l++) begin
      bus0.in_i[l*16 +: 16]     = 16'(i0_tab[n] + (lane_ramp ? l : 0));
      bus0.in_q[l*16 +: 16]     = 16'(q0_tab[n]);
      bus0.in_i[(5+l)*16 +: 16] = 16'(i1_tab[n]);
      bus0.in_q[(5+l)*16 +: 16] = 16'(q1_tab[n]);
    end
  endtask

  task automatic chk_vals(input string tag);
    check_eq({tag, ":i0"},    longint'($signed(bus0.i_val[31:0])),  e0[0]);
    check_eq({tag, ":q0"},    longint'($signed(bus0.q_val[31:0])),  e0[1]);
    check_eq({tag, ":i1"},    longint'($signed(bus0.i_val[63:32])), e0[2]);
    check_eq({tag, ":q1"},    longint'($signed(bus0.q_val[63:32])), e0[3]);
    check_eq({tag, ":i0_20"}, longint'($signed(bus1.i_val[19:0])),  e1[0]);
    check_eq({tag, ":q0_20"}, longint'($signed(bus1.q_val[19:0])),  e1[1]);
    check_eq({tag, ":i1_20"}, longint'($signed(bus1.i_val[39:20])), e1[2]);
    check_eq({tag, ":q1_20"}, longint'($signed(bus1.q_val[39:20])), e1[3]);
  endtask

  // Entry n=0 carries the trigger into edge k; after the n-th step the bench sits between edges k+n and k+n+1.
  task automatic run_win(input string tag, input int ncyc, input int exp_at);
    for (int n = 0; n < ncyc; n++) begin
      drive(n);
      @(negedge clk);
      check_eq({tag, ":iq_valid"},    longint'(bus0.iq_valid), longint'(n == exp_at));
      check_eq({tag, ":iq_valid_20"}, longint'(bus1.iq_valid), longint'(n == exp_at));
      if (n == 0) check_eq({tag, ":busy_start"}, longint'(busy0), 1);
      if (n == exp_at) chk_vals(tag);
    end
    check_eq({tag, ":busy_end"}, longint'(busy0), 0);
    trigger  = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic load_cfg(input int d, input int l);
    cfg_delay  = 16'(d);
    cfg_length = 16'(l);
    cfg_load   = 1'b1;
    @(negedge clk);
    cfg_load   = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    cfg_delay     = '0;
    cfg_length    = '0;
    cfg_load      = 1'b0;
    trigger       = 1'b0;
    bus0.in_valid = 1'b0;
    bus0.in_i     = '0;
    bus0.in_q     = '0;
    @(negedge clk);
    check_eq("rst:busy",     longint'(busy0),         0);
    check_eq("rst:overrun",  longint'(ovr0),          0);
    check_eq("rst:iq_valid", longint'(bus0.iq_valid), 0);
    check_eq("rst:i_val",    longint'(bus0.i_val),    0);
    check_eq("rst:q_val",    longint'(bus0.q_val),    0);
    check_eq("rst:i_val_20", longint'(bus1.i_val),    0);
    rst = 1'b1;
    @(negedge clk);

    // basic sums
    load_cfg(0, 4);
    fill(1, 1, -2, 100, 0);
    set_exp(20, -40, 2000, 0);
    run_win("basic", 6, 4);

    // lane ordering inside a channel
    load_cfg(0, 2);
    fill(1, 10, -3, 5, -1);
    lane_ramp = 1'b1;
    set_exp(120, -30, 50, -10);
    run_win("lanes", 4, 2);

    // delay window covers cycles n=4,5
    load_cfg(3, 2);
    fill(1, 0, 0, 0, 0);
    for (int n = 0; n < 16; n++) begin
      i0_tab[n] = n;
      q0_tab[n] = -n;
      i1_tab[n] = 2 * n;
    end
    set_exp(45, -45, 90, 0);
    run_win("delay", 7, 5);

    // in_valid gaps carry garbage that must be ignored
    load_cfg(0, 3);
    fill(1, 7, -7, 0, 0);
    vld_tab[2] = 0; i0_tab[2] = 1000; q0_tab[2] = 1000;
    vld_tab[4] = 0; i0_tab[4] = 1000; q0_tab[4] = 1000;
    set_exp(105, -105, 0, 0);
    run_win("gaps", 7, 5);

    // saturation in both directions on both channels
    load_cfg(0, 8);
    fill(1, 32767, -32768, -32768, 32767);
    set_exp(1310680, -1310720, -1310720, 1310680);
    e1[0] = 524287; e1[1] = -524288; e1[2] = -524288; e1[3] = 524287;
    run_win("sat", 10, 8);

    // clamped accumulator pulled back by opposite-sign input
    load_cfg(0, 10);
    fill(1, 32767, 0, 0, 0);
    i0_tab[9]  = -32768;
    i0_tab[10] = -32768;
    set_exp(983000, 0, 0, 0);
    e1[0] = 196607;
    run_win("pullback", 12, 10);

    // second trigger in INTEG and cfg_load while busy are both ignored
    load_cfg(0, 4);
    cfg_length = 16'd2;
    fill(1, 3, 0, 0, 0);
    trg_tab[2] = 1;
    ld_tab[1]  = 1;
    set_exp(60, 0, 0, 0);
    run_win("overrun", 6, 4);
    check_eq("overrun:set",    longint'(ovr0), 1);
    check_eq("overrun:set_20", longint'(ovr1), 1);

    load_cfg(0, 0);
    check_eq("overrun:clear", longint'(ovr0), 0);

    // zero-length window
    fill(1, 5, 5, 5, 5);
    set_exp(0, 0, 0, 0);
    run_win("len0", 2, 0);

    // load coinciding with trigger: new window applies
    cfg_delay  = 16'd0;
    cfg_length = 16'd3;
    fill(1, 2, 0, 0, 0);
    ld_tab[0] = 1;
    set_exp(30, 0, 0, 0);
    run_win("load_trig", 5, 3);

    // asynchronous reset in the second integration cycle
    load_cfg(0, 4);
    fill(1, 9, 9, 9, 9);
    drive(0);
    @(negedge clk);
    drive(1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("arst:busy",     longint'(busy0),         0);
    check_eq("arst:iq_valid", longint'(bus0.iq_valid), 0);
    check_eq("arst:i_val",    longint'(bus0.i_val),    0);
    check_eq("arst:q_val",    longint'(bus0.q_val),    0);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check_eq("arst:no_strobe", longint'(bus0.iq_valid), 0);
      check_eq("arst:idle",      longint'(busy0),         0);
    end
    bus0.in_valid = 1'b0;

    // configuration was cleared by reset: trigger alone gives an immediate zero result
    fill(1, 4, 0, 0, 0);
    set_exp(0, 0, 0, 0);
    run_win("arst_cfg0", 2, 0);

    load_cfg(1, 2);
    fill(1, 4, 0, 0, 0);
    set_exp(40, 0, 0, 0);
    run_win("arst_fresh", 5, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demod_iq_integrator.md
# demod_iq_integrator

Parametrised, multi-channel successor to the IQ demod front end. It integrates pre-mixed I and Q sample streams (LANES samples per clock per channel) over a programmable, trigger-started window after a programmable delay, and presents one signed I/Q sum pair per channel with a single-cycle valid strobe. It sits between the FCx5 data-stream inputs and the state-discrimination/histogram stage, and feeds that stage's `i_val`/`q_val`/`iq_valid` inputs.

## Interface
- `N_CH`, 2: number of independent I/Q channels, integrated in lockstep.
- `LANES`, 5: samples per clock per stream.
- `DW`, 16: signed sample width.
- `AW`, 32: signed accumulator/result width; must satisfy AW ≥ DW + clog2(LANES).
- `LW`, 16: width of the delay and length counters.

- `clk`, in, 1: single clock; every register is on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `cfg_delay`, in, LW: number of valid cycles discarded after the trigger.
- `cfg_length`, in, LW: number of valid cycles integrated.
- `cfg_load`, in, 1: latches `cfg_delay`/`cfg_length` and clears `overrun`; honoured in IDLE only.
- `trigger`, in, 1: start request, rising-edge sensitive.
- `in_i`, in, N_CH·LANES·DW: I samples; channel c, lane l at bits [(c·LANES+l)·DW +: DW].
- `in_q`, in, N_CH·LANES·DW: Q samples, same packing.
- `in_valid`, in, 1: the sample bus is valid this cycle.
- `i_val`, out, N_CH·AW: I result; channel c at [c·AW +: AW].
- `q_val`, out, N_CH·AW: Q result, same packing.
- `iq_valid`, out, 1: one-cycle strobe that marks a new result.
- `busy`, out, 1: high whenever the state is not IDLE.
- `overrun`, out, 1: sticky flag for a trigger that arrived while busy.

## Operation
- Reset values: state IDLE; cfg registers 0; accumulators, `i_val`, `q_val` all 0; `iq_valid`, `busy`, `overrun` all 0; `trig_d` (registered previous trigger) 0.
- Trigger event: `trigger & ~trig_d`.
- The FSM has four states: IDLE, DELAY, INTEG, DONE.
- IDLE, on a trigger event:
  - Clear the accumulators and counter.
  - If `cfg_delay` ≠ 0, go to DELAY.
  - Else if `cfg_length` ≠ 0, go to INTEG.
  - Else go to DONE, which outputs zeros.
- DELAY:
  - The counter increments on each `in_valid` cycle.
  - On the `cfg_delay`-th valid cycle, clear the counter and go to INTEG, or to DONE if `cfg_length` = 0.
  - Samples arriving in DELAY are discarded.
- INTEG:
  - On each `in_valid` cycle, acc[c] ← sat(acc[c] + Σ_l sext(sample[c][l])), separately for I and Q.
  - The counter increments on the same cycles.
  - On the `cfg_length`-th valid cycle, load `i_val`/`q_val` with the saturated final sums, set `iq_valid`, and go to DONE.
- DONE: lasts one cycle, then goes to IDLE; `iq_valid` clears at that edge.
- Cycles with `in_valid` = 0 never advance any counter or accumulator.
- Arithmetic:
  - The lane sum is full precision (DW + clog2(LANES) bits), sign-extended to AW.
  - The accumulate step saturates to [−2^(AW−1), 2^(AW−1)−1]. Once an accumulator saturates it stays clamped, except that further additions of the opposite sign may pull it back.
- Configuration:
  - Configuration is used as latched; `cfg_load` while busy is ignored.
  - If `cfg_load` and a trigger event occur together in IDLE, the load takes effect first, so the new window applies.
- Overrun: a trigger event while `busy` (DELAY, INTEG or DONE) is ignored and sets `overrun`. Only `cfg_load` in IDLE or reset clears it.
- `i_val`/`q_val` hold their last result until the next DONE load.
- All channels share one FSM and one counter.

## Timing
- Trigger event sampled at edge k: `busy` = 1 from edge k.
- Result latency: with D = `cfg_delay`, L = `cfg_length` and continuous `in_valid`, the last sample is accepted at edge k+D+L. `iq_valid` is high between edges k+D+L and k+D+L+1, and the next trigger can be accepted at edge k+D+L+2 or later.
- Each `in_valid` gap extends the window by exactly the gap length.
- Reset mid-window (rst low at any time): all state returns to reset values immediately, asynchronously. No `iq_valid` is produced for the aborted window.
- Throughput: one LANES-wide word per clock, with no backpressure.

## Test plan
- Basic sums: N_CH=2, all ch0 I lanes = 1, all ch0 Q lanes = −2, ch1 I = 100, ch1 Q = 0; D=0, L=4, continuous valid, trigger at edge k -> `iq_valid` only in cycle k+4; ch0 i=20, q=−40; ch1 i=2000, q=0.
- Delay: I lane value = cycle index n (all lanes), trigger at n=0, D=3, L=2 -> I = 5·(4+5) = 45 (the window covers the valid cycles at n=4 and n=5).
- Valid gaps: D=0, L=3, I = 7, `in_valid` toggling 1,0,1,0,1 -> I = 105; `iq_valid` lands 5 cycles after the trigger.
- Saturation: AW=20, every lane +32767, L=8 -> I = 524287. Same setup with every lane −32768 -> I = −524288.
- Overrun and config: a second trigger during INTEG -> `overrun`=1 and the result is unchanged. `cfg_load` while busy is ignored (old window length is used). `cfg_load` in IDLE -> `overrun` = 0. L=0 -> zeros with a 1-cycle `iq_valid`.
- Reset mid-INTEG: pulse rst low in the 2nd integration cycle -> all outputs 0 and no `iq_valid`. A fresh trigger then produces a correct result.
